dot_sched: RTL and testbench
============================

Name: dot_sched

Overview:
- Sequencer for the `dot` convolution engine; runs a programmed number of passes, one per channel-select (cs) value.
- Per pass: raises `dot_load` and holds `dot_cs`, waits for `dot_valid`, then drains the 12x32 result vector to a result RAM as 12 row words.
- Then drops `dot_load` for one cycle so `dot` rewinds its address and row counters.
- Sits between the layer-level top controller (start/done) and `dot` plus the output buffer RAM.

Parameters:
- ROWS, 12, result rows per pass; matches `dot` q_temp depth.
- COLS, 32, elements per row; matches the dot_channel count.
- ADDR_W, 9, result-RAM address width.
- TIMEOUT, 4096, max cycles in RUN waiting for `dot_valid` before aborting with error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  synchronous cancel; honoured in any non-IDLE state
- num_cs  in  4  number of passes; 0 is legal
- cs_base  in  4  cs value for pass 0
- base_addr  in  ADDR_W  result-RAM address of pass 0, row 0
- dot_load  out  1  load to `dot`
- dot_cs  out  4  cs to `dot`
- dot_valid  in  1  valid from `dot`
- dot_q  in  ROWS*COLS*`data_len  results from `dot`; row j, column i at bit offset (ROWS*i+j)*`data_len
- wr_en  out  1  result-RAM write strobe
- wr_addr  out  ADDR_W  result-RAM address
- wr_data  out  COLS*`data_len  row word; column i at offset i*`data_len
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag; cleared when a start is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE, pass=0, row=0, timer=0. All outputs 0.
- States: IDLE, RUN, DRAIN, GAP, FIN.
- IDLE -> RUN when start=1. On that edge:
  - latch num_cs, cs_base, base_addr;
  - clear err;
  - pass=0.
  - If num_cs=0, go to FIN instead.
- In IDLE, start is ignored while busy; latched config does not change mid-run.
- RUN: dot_load=1, dot_cs=cs_base+pass (4-bit wrap). timer increments every cycle.
  - dot_valid=1 -> DRAIN, row=0, timer=0.
  - timer=TIMEOUT-1 with no valid -> err=1, go to FIN.
- DRAIN: dot_load stays 1, so `dot` holds q stable. One write per cycle for ROWS cycles:
  - wr_en=1;
  - wr_addr=base_addr+pass*ROWS+row, truncated to ADDR_W (wraps);
  - wr_data column i = dot_q[(ROWS*i+row)*`data_len +: `data_len].
  - After row=ROWS-1 -> GAP.
- Write outputs are combinational from state/row/latched config and dot_q. First write occurs in the cycle after dot_valid is sampled.
- GAP: exactly one cycle with dot_load=0, wr_en=0. Then:
  - pass+1<num_cs -> pass+=1, go to RUN;
  - otherwise -> FIN.
- FIN: done=1 for exactly one cycle, dot_load=0, busy=1. Next state IDLE.
- abort=1 in RUN, DRAIN or GAP:
  - next state IDLE, dot_load=0 next cycle;
  - no done pulse, err unchanged;
  - a write in progress in the abort cycle still completes in that cycle.
- abort in FIN is ignored; done still pulses.
- abort and start together in IDLE: start wins.
- dot_valid outside RUN is ignored.
- Latency: start to first dot_load=1 is 1 cycle.
- Per-pass overhead beyond `dot` compute is ROWS+1 cycles (drain plus gap).

Decomposition:
- Shared package/include (alongside num_data.v): `data_len`, state encoding constants, and the ROWS/COLS defaults used by `dot` and this block.
- One natural sub-module, `dot_row_sel`: combinational column gather of row `row` from dot_q into wr_data. The FSM, counters and timer stay in `dot_sched`.

Test Plan:
- num_cs=1, cs_base=3, base_addr=0x010; model `dot` asserts valid 40 cycles after load -> dot_cs=3; 12 writes at 0x010..0x01B on consecutive cycles; wr_data matches the gather formula; one GAP cycle; done at GAP+1; err=0.
- num_cs=3, cs_base=14, base_addr=0x1F0 -> dot_cs sequence 14, 15, 0; 36 writes with address wrap 0x1FF->0x000; one dot_load=0 cycle between passes; single done pulse.
- num_cs=0 -> done one cycle after the start cycle (FIN), dot_load never high, wr_en never high.
- dot_valid held low with TIMEOUT=16 -> dot_load high for exactly 16 cycles; err=1 and done pulse; next start clears err.
- abort on the 5th DRAIN cycle -> exactly 5 writes; IDLE next cycle; dot_load=0; no done. Also: start while busy is ignored; rst_n asserted mid-RUN clears all outputs immediately (asynchronously).

Source files
------------

// File: rtl/dot_sched_pkg.sv
// Shared definitions for the dot convolution engine and its pass sequencer.
// Element width, default result geometry and the sequencer state encoding.
package dot_sched_pkg;

   localparam int DATA_LEN = 8;
   localparam int ROWS_DEF = 12;
   localparam int COLS_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_GAP   = 3'd3,
      ST_FIN   = 3'd4
   } state_e;

   // dot_q stores row j of column i at element index ROWS*i + j.
   function automatic int unsigned elem_offset(input int unsigned rows,
                                               input int unsigned col,
                                               input int unsigned row);
      return (rows * col + row) * DATA_LEN;
   endfunction

endpackage

// File: rtl/dot_row_sel.sv
// Combinational gather of one result row from the column-major dot_q vector
// into a packed row word (column i at offset i*DATA_LEN).
module dot_row_sel
   import dot_sched_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int COLS  = COLS_DEF,
   parameter int ROW_W = $clog2(ROWS_DEF)
) (
   input  logic [ROWS*COLS*DATA_LEN-1:0] dot_q,
   input  logic [ROW_W-1:0]              row,
   output logic [COLS*DATA_LEN-1:0]      row_word
);

   always_comb begin
      row_word = '0;
      for (int unsigned i = 0; i < COLS; i++) begin
         row_word[i*DATA_LEN +: DATA_LEN] = dot_q[elem_offset(ROWS, i, 32'(row)) +: DATA_LEN];
      end
   end

endmodule

// File: rtl/dot_sched.sv
// Pass sequencer for the dot engine: loads each cs value in turn, waits for
// dot_valid, drains ROWS row words into the result RAM, then rewinds dot.
module dot_sched
   import dot_sched_pkg::*;
#(
   parameter int ROWS    = ROWS_DEF,
   parameter int COLS    = COLS_DEF,
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [3:0]                    num_cs,
   input  logic [3:0]                    cs_base,
   input  logic [ADDR_W-1:0]             base_addr,
   output logic                          dot_load,
   output logic [3:0]                    dot_cs,
   input  logic                          dot_valid,
   input  logic [ROWS*COLS*DATA_LEN-1:0] dot_q,
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [COLS*DATA_LEN-1:0]      wr_data,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   state_e              state_q, state_d;
   logic [3:0]          pass_q, pass_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [3:0]          num_cs_q, num_cs_d;
   logic [3:0]          cs_base_q, cs_base_d;
   logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
   logic                err_q, err_d;
   logic                dot_load_q, dot_load_d;
   logic [3:0]          dot_cs_q, dot_cs_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [COLS*DATA_LEN-1:0] row_word;
   logic [ADDR_W-1:0]        addr_calc;

   dot_row_sel #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .ROW_W (ROW_W)
   ) u_row_sel (
      .dot_q    (dot_q),
      .row      (row_q),
      .row_word (row_word)
   );

   always_comb begin
      state_d     = state_q;
      pass_d      = pass_q;
      row_d       = row_q;
      timer_d     = timer_q;
      num_cs_d    = num_cs_q;
      cs_base_d   = cs_base_q;
      base_addr_d = base_addr_q;
      err_d       = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_cs_d    = num_cs;
               cs_base_d   = cs_base;
               base_addr_d = base_addr;
               err_d       = 1'b0;
               pass_d      = '0;
               row_d       = '0;
               timer_d     = '0;
               state_d     = (num_cs == 4'd0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (dot_valid) begin
               state_d = ST_DRAIN;
               row_d   = '0;
               timer_d = '0;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (row_q == ROW_W'(ROWS - 1)) begin
               state_d = ST_GAP;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (({1'b0, pass_q} + 5'd1) < {1'b0, num_cs_q}) begin
               pass_d  = pass_q + 4'd1;
               timer_d = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs registered from the next state so they line up with state_q.
      dot_load_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      dot_cs_d   = (state_d == ST_IDLE) ? 4'd0 : (cs_base_d + pass_d);
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pass_q      <= '0;
         row_q       <= '0;
         timer_q     <= '0;
         num_cs_q    <= '0;
         cs_base_q   <= '0;
         base_addr_q <= '0;
         err_q       <= 1'b0;
         dot_load_q  <= 1'b0;
         dot_cs_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pass_q      <= pass_d;
         row_q       <= row_d;
         timer_q     <= timer_d;
         num_cs_q    <= num_cs_d;
         cs_base_q   <= cs_base_d;
         base_addr_q <= base_addr_d;
         err_q       <= err_d;
         dot_load_q  <= dot_load_d;
         dot_cs_q    <= dot_cs_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign addr_calc = base_addr_q + ADDR_W'(32'(pass_q) * 32'(ROWS)) + ADDR_W'(row_q);

   assign dot_load = dot_load_q;
   assign dot_cs   = dot_cs_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign wr_en    = (state_q == ST_DRAIN);
   assign wr_addr  = wr_en ? addr_calc : '0;
   assign wr_data  = wr_en ? row_word : '0;

endmodule

// File: tb/tb_dot_sched.sv
// Self-checking bench for dot_sched: a reactive model of dot plus scenario
// tasks comparing the write stream, cs sequence and handshakes to the rules.
module tb_dot_sched;
   import dot_sched_pkg::*;

   localparam int ROWS = 12;
   localparam int COLS = 32;
   localparam int AW   = 9;

   logic                          clk = 1'b0;
   logic                          rst_n = 1'b0;
   logic                          start = 1'b0, abort = 1'b0;
   logic                          start2 = 1'b0, abort2 = 1'b0;
   logic [3:0]                    num_cs = '0, cs_base = '0;
   logic [AW-1:0]                 base_addr = '0;
   logic                          dot_valid = 1'b0, dot_valid2 = 1'b0;
   logic [ROWS*COLS*DATA_LEN-1:0] dot_q = '0;

   logic                     dot_load, wr_en, busy, done, err;
   logic [3:0]               dot_cs;
   logic [AW-1:0]            wr_addr;
   logic [COLS*DATA_LEN-1:0] wr_data;
   logic                     dot_load2, wr_en2, busy2, done2, err2;
   logic [3:0]               dot_cs2;
   logic [AW-1:0]            wr_addr2;
   logic [COLS*DATA_LEN-1:0] wr_data2;

   int checks = 0;
   int errors = 0;
   int ld_cnt = 0;
   int model_lat = 40;
   bit raised = 0;

   always #5 clk = ~clk;

   dot_sched dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_cs(num_cs), .cs_base(cs_base), .base_addr(base_addr),
      .dot_load(dot_load), .dot_cs(dot_cs), .dot_valid(dot_valid), .dot_q(dot_q),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   dot_sched #(.TIMEOUT(16)) dut_to (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
      .num_cs(num_cs), .cs_base(cs_base), .base_addr(base_addr),
      .dot_load(dot_load2), .dot_cs(dot_cs2), .dot_valid(dot_valid2), .dot_q(dot_q),
      .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
      .busy(busy2), .done(done2), .err(err2)
   );

   // Row word as the result RAM should see it: column i holds element (i, r).
   function automatic logic [COLS*DATA_LEN-1:0] exp_row(input int r);
      logic [COLS*DATA_LEN-1:0] w;
      w = '0;
      for (int i = 0; i < COLS; i++) w[i*DATA_LEN +: DATA_LEN] = dot_q[(ROWS*i + r)*DATA_LEN +: DATA_LEN];
      return w;
   endfunction

   // Behaviour of dot: after model_lat cycles of load, present fresh results and valid.
   task automatic dot_step();
      if (dot_load) begin
         ld_cnt++;
         if (!dot_valid && ld_cnt >= model_lat) begin
            for (int k = 0; k < ROWS*COLS*DATA_LEN/32; k++) dot_q[k*32 +: 32] = $urandom;
            dot_valid = 1'b1;
            raised = 1'b1;
         end
      end else begin
         ld_cnt = 0;
         dot_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({dot_load, dot_cs, wr_en, wr_addr, busy, done, err} !== '0 || wr_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got load=%0b cs=%0d wr=%0b addr=%0h busy=%0b done=%0b err=%0b, want all 0",
                  dot_load, dot_cs, wr_en, wr_addr, busy, done, err);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_run(input string name, input int num, input int csb, input int base,
                           input int lat, input bit poke);
      int wr_cnt = 0, gaps = 0, done_cnt = 0, done_cyc = -1, last_gap = 0, cyc = 0, pass;
      int budget = 60 + num*(lat + 20);
      bit prev_wr = 0;
      logic [AW-1:0] ea;
      logic [COLS*DATA_LEN-1:0] ed;
      model_lat = lat; raised = 0;
      num_cs = 4'(num); cs_base = 4'(csb); base_addr = AW'(base); start = 1'b1;
      @(negedge clk); start = 1'b0; cyc = 1;
      forever begin
         if (cyc > budget) begin
            checks++; errors++;
            $display("FAIL %s_budget: no completion within %0d cycles", name, budget);
            break;
         end
         pass = wr_cnt / ROWS;
         if (cyc == 1) begin
            checks++;
            if (busy !== 1'b1 || dot_load !== (num > 0)) begin
               errors++;
               $display("FAIL %s_first_cycle: busy=%0b load=%0b, want busy=1 load=%0b", name, busy, dot_load, num > 0);
            end
         end
         if (dot_load) begin
            checks++;
            if (dot_cs !== 4'(csb + pass)) begin
               errors++;
               $display("FAIL %s_dot_cs: got %0d want %0d (pass %0d)", name, dot_cs, 4'(csb + pass), pass);
            end
         end
         if (raised) begin
            checks++;
            raised = 0;
            if (wr_en !== 1'b1) begin
               errors++;
               $display("FAIL %s_first_write: wr_en=%0b the cycle after valid, want 1", name, wr_en);
            end
         end
         if (wr_en) begin
            ea = AW'(base + wr_cnt);
            ed = exp_row(wr_cnt % ROWS);
            checks++;
            if (wr_addr !== ea || wr_data !== ed) begin
               errors++;
               $display("FAIL %s_write%0d: addr=%h data=%h, want addr=%h data=%h", name, wr_cnt, wr_addr, wr_data, ea, ed);
            end
            wr_cnt++;
         end else if (prev_wr && (wr_cnt % ROWS) != 0) begin
            checks++; errors++;
            $display("FAIL %s_drain_break: writes stopped after %0d, want multiple of %0d", name, wr_cnt, ROWS);
         end
         if (busy && !dot_load && !done) begin
            gaps++; last_gap = cyc;
            checks++;
            if (!prev_wr || wr_en) begin
               errors++;
               $display("FAIL %s_gap_place: gap at cycle %0d prev_wr=%0b wr_en=%0b, want 1/0", name, cyc, prev_wr, wr_en);
            end
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (poke && cyc == 3) begin
            start = 1'b1; num_cs = 4'(num + 2); cs_base = 4'(csb + 5); base_addr = AW'(base + 100);
         end else begin
            start = 1'b0;
         end
         prev_wr = wr_en;
         if (done_cnt > 0 && cyc == done_cyc + 1) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
               errors++;
               $display("FAIL %s_idle_after_done: busy=%0b done=%0b, want 0/0", name, busy, done);
            end
            break;
         end
         dot_step();
         @(negedge clk); cyc++;
      end
      checks++;
      if (wr_cnt != ROWS*num || gaps != num || done_cnt != 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL %s_totals: writes=%0d gaps=%0d dones=%0d err=%0b, want %0d/%0d/1/0",
                  name, wr_cnt, gaps, done_cnt, err, ROWS*num, num);
      end
      checks++;
      if (done_cyc != ((num == 0) ? 1 : last_gap + 1)) begin
         errors++;
         $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, (num == 0) ? 1 : last_gap + 1);
      end
      dot_step();
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int load_cnt = 0, done_cnt = 0, wr_seen = 0, cyc;
      num_cs = 4'd2; cs_base = 4'd1; base_addr = '0; start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      for (cyc = 1; cyc < 200; cyc++) begin
         if (dot_load2) load_cnt++;
         if (wr_en2) wr_seen++;
         if (done2) begin
            done_cnt++;
            checks++;
            if (err2 !== 1'b1) begin errors++; $display("FAIL timeout_err_at_done: got %0b want 1", err2); end
         end
         if (done_cnt > 0 && !done2) break;
         @(negedge clk);
      end
      checks++;
      if (load_cnt != 16 || done_cnt != 1 || wr_seen != 0 || err2 !== 1'b1 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL timeout_totals: load_cycles=%0d dones=%0d writes=%0d err=%0b busy=%0b, want 16/1/0/1/0",
                  load_cnt, done_cnt, wr_seen, err2, busy2);
      end
      start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      checks++;
      if (err2 !== 1'b0 || busy2 !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err_clear: err=%0b busy=%0b, want 0/1", err2, busy2);
      end
      for (cyc = 0; cyc < 100 && !done2; cyc++) @(negedge clk);
      checks++;
      if (done2 !== 1'b1 || err2 !== 1'b1) begin
         errors++;
         $display("FAIL timeout_second_run: done=%0b err=%0b, want 1/1", done2, err2);
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int wr_cnt = 0, bad = 0, cyc;
      int base = int'($urandom_range(0, 511));
      model_lat = 6; raised = 0;
      num_cs = 4'd2; cs_base = 4'($urandom); base_addr = AW'(base); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (cyc = 0; cyc < 100 && wr_cnt < 5; cyc++) begin
         if (wr_en) begin
            checks++;
            if (wr_addr !== AW'(base + wr_cnt)) begin
               errors++;
               $display("FAIL abort_write_addr: got %h want %h", wr_addr, AW'(base + wr_cnt));
            end
            wr_cnt++;
         end
         if (wr_cnt == 5) abort = 1'b1;
         else dot_step();
         @(negedge clk);
      end
      abort = 1'b0;
      checks++;
      if (wr_cnt != 5 || busy !== 1'b0 || dot_load !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_stop: writes=%0d busy=%0b load=%0b wr=%0b done=%0b, want 5/0/0/0/0",
                  wr_cnt, busy, dot_load, wr_en, done);
      end
      for (cyc = 0; cyc < 20; cyc++) begin
         if (wr_en || done || busy) bad++;
         dot_step();
         @(negedge clk);
      end
      checks++;
      if (bad != 0 || err !== 1'b0) begin
         errors++;
         $display("FAIL abort_quiet: activity_cycles=%0d err=%0b, want 0/0", bad, err);
      end
   endtask

   task automatic test_start_abort_same();
      num_cs = 4'd1; cs_base = 4'd7; start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b1 || dot_load !== 1'b1 || dot_cs !== 4'd7) begin
         errors++;
         $display("FAIL start_beats_abort: busy=%0b load=%0b cs=%0d, want 1/1/7", busy, dot_load, dot_cs);
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || dot_load !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_run: busy=%0b load=%0b done=%0b, want 0/0/0", busy, dot_load, done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      model_lat = 40;
      num_cs = 4'd2; cs_base = 4'd9; base_addr = 9'h055; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) begin dot_step(); @(negedge clk); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dot_load, dot_cs, wr_en, wr_addr, busy, done, err} !== '0 || wr_data !== '0) begin
         errors++;
         $display("FAIL reset_mid_run: load=%0b cs=%0d wr=%0b busy=%0b done=%0b err=%0b, want all 0",
                  dot_load, dot_cs, wr_en, busy, done, err);
      end
      @(negedge clk); rst_n = 1'b1;
      ld_cnt = 0; dot_valid = 1'b0; raised = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_run("single", 1, 3, 'h010, 40, 1'b0);
      test_run("wrap", 3, 14, 'h1F0, 12, 1'b0);
      test_run("zero", 0, 5, 'h020, 10, 1'b0);
      test_run("busy_start", 1, 5, 'h040, 8, 1'b1);
      for (int k = 0; k < 4; k++)
         test_run($sformatf("rand%0d", k), int'($urandom_range(1, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 511)), int'($urandom_range(1, 30)), 1'b0);
      test_timeout();
      test_abort();
      test_start_abort_same();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
